plot_sweep_controller: RTL

Sequences a single shared graph evaluator across the display width once all coefficients are confirmed. For each screen column it requests a y-value for graph 1, then for graph 2, over a valid/ready request channel with a separate result return. It converts each result to an OLED row and issues one write per sample into the plot column buffer. It sits between the coefficient entry logic / main FSM and the evaluator plus frame buffer.

---
 rtl/plot_sweep_controller_if.sv | 26 ++
 rtl/plot_sweep_controller.sv | 137 +++++++++++++
 2 files changed

// File: rtl/plot_sweep_controller_if.sv
// Evaluator request/result channel and column-buffer write port of the plot sweep controller.
interface plot_sweep_controller_if;
    logic        eval_valid;
    logic        eval_ready;
    logic        eval_slot;
    logic [7:0]  eval_x;
    logic        res_valid;
    logic [15:0] res_y;
    logic        wr_en;
    logic [6:0]  wr_col;
    logic        wr_slot;
    logic [5:0]  wr_row;
    logic        wr_visible;

    modport master (
        output eval_valid, eval_slot, eval_x,
        input  eval_ready, res_valid, res_y,
        output wr_en, wr_col, wr_slot, wr_row, wr_visible
    );

    modport slave (
        input  eval_valid, eval_slot, eval_x,
        output eval_ready, res_valid, res_y,
        input  wr_en, wr_col, wr_slot, wr_row, wr_visible
    );
endinterface

// File: rtl/plot_sweep_controller.sv
// Sweeps the shared graph evaluator across every screen column for graphs 1 and 2,
// converting each returned y into an OLED row and writing it into the column buffer.
module plot_sweep_controller #(
    parameter int WIDTH    = 96,
    parameter int HEIGHT   = 64,
    parameter int X_ORIGIN = 48,
    parameter int Y_ORIGIN = 32,
    parameter int TIMEOUT  = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic abort,
    input  logic g1_en,
    input  logic g2_en,
    plot_sweep_controller_if.master sweep,
    output logic busy,
    output logic done,
    output logic timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ISSUE = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]         state;
    logic [6:0]         col;
    logic               slot;
    logic [CNT_W-1:0]   wait_cnt;
    logic signed [15:0] y_q;
    logic               tout_q;
    logic signed [16:0] row;
    logic               row_vis;
    logic               start_ok;

    assign start_ok = start && (state == IDLE || state == DONE);

    // 17-bit arithmetic keeps extreme results such as -32768 from wrapping into range.
    always_comb begin
        row     = $signed(17'(Y_ORIGIN)) - $signed({y_q[15], y_q});
        row_vis = !tout_q && !row[16] && (row[15:0] < 16'(HEIGHT));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            col         <= '0;
            slot        <= 1'b0;
            wait_cnt    <= '0;
            y_q         <= '0;
            tout_q      <= 1'b0;
            timeout_err <= 1'b0;
        end else if (abort) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        timeout_err <= 1'b0;
                        col         <= '0;
                        if (g1_en) begin
                            slot  <= 1'b0;
                            state <= ISSUE;
                        end else if (g2_en) begin
                            slot  <= 1'b1;
                            state <= ISSUE;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                ISSUE: begin
                    if (sweep.eval_ready) begin
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (sweep.res_valid) begin
                        y_q    <= sweep.res_y;
                        tout_q <= 1'b0;
                        state  <= WRITE;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        tout_q      <= 1'b1;
                        timeout_err <= 1'b1;
                        state       <= WRITE;
                    end
                end
                WRITE: begin
                    if (!slot && g2_en) begin
                        slot  <= 1'b1;
                        state <= ISSUE;
                    end else if (col == 7'(WIDTH - 1)) begin
                        state <= DONE;
                    end else begin
                        col   <= col + 1'b1;
                        slot  <= !g1_en;
                        state <= ISSUE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        sweep.eval_valid = 1'b0;
        sweep.eval_slot  = 1'b0;
        sweep.eval_x     = '0;
        sweep.wr_en      = 1'b0;
        sweep.wr_col     = '0;
        sweep.wr_slot    = 1'b0;
        sweep.wr_row     = '0;
        sweep.wr_visible = 1'b0;
        if (state == ISSUE) begin
            sweep.eval_valid = 1'b1;
            sweep.eval_slot  = slot;
            sweep.eval_x     = 8'(col) - 8'(X_ORIGIN);
        end
        if (state == WRITE) begin
            sweep.wr_en      = 1'b1;
            sweep.wr_col     = col;
            sweep.wr_slot    = slot;
            sweep.wr_visible = row_vis;
            sweep.wr_row     = row_vis ? row[5:0] : 6'd0;
        end
    end

    assign busy = (state == ISSUE) || (state == WAIT) || (state == WRITE);
    assign done = (state == DONE);

endmodule
